// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 signed max-pool engine: walks a square feature map, issues four reads per window
// and writes one pooled pixel per cycle. Define MAXPOOL2X2_RELU_EN to clamp negative results to 0.
module maxpool2x2_engine #(
  parameter int IMG_W = 24,
  parameter int DW    = 16,
  localparam int AW_IN  = $clog2(IMG_W * IMG_W),
  localparam int AW_OUT = $clog2((IMG_W / 2) * (IMG_W / 2))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW_IN-1:0]  rd_addr0,
  output logic [AW_IN-1:0]  rd_addr1,
  output logic [AW_IN-1:0]  rd_addr2,
  output logic [AW_IN-1:0]  rd_addr3,
  input  logic [DW-1:0]     rd_data0,
  input  logic [DW-1:0]     rd_data1,
  input  logic [DW-1:0]     rd_data2,
  input  logic [DW-1:0]     rd_data3,
  output logic              wr_en,
  output logic [AW_OUT-1:0] wr_addr,
  output logic [DW-1:0]     wr_data
);

  localparam int HALF = IMG_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW_IN-1:0] COL_STEP  = AW_IN'(2);
  localparam logic [AW_IN-1:0] ROW_STEP  = AW_IN'(IMG_W + 2);
  localparam logic [AW_IN-1:0] OFS_RIGHT = AW_IN'(1);
  localparam logic [AW_IN-1:0] OFS_DOWN  = AW_IN'(IMG_W);
  localparam logic [AW_IN-1:0] OFS_DIAG  = AW_IN'(IMG_W + 1);
  localparam logic [CW-1:0]    LAST_IDX  = CW'(HALF - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic [AW_IN-1:0]  addr0_q, addr0_d;
  logic [AW_IN-1:0]  addr1_q, addr1_d;
  logic [AW_IN-1:0]  addr2_q, addr2_d;
  logic [AW_IN-1:0]  addr3_q, addr3_d;
  logic              drainCnt_q, drainCnt_d;
  logic              dataVld_q, dataVld_d;
  logic [AW_OUT-1:0] wrIdx_q, wrIdx_d;
  logic              wrEn_q, wrEn_d;
  logic [AW_OUT-1:0] wrAddr_q, wrAddr_d;
  logic [DW-1:0]     wrData_q, wrData_d;

  logic lastCol;
  logic lastWin;

  logic signed [DW-1:0] pix0, pix1, pix2, pix3;
  logic signed [DW-1:0] maxTop, maxBot, maxAll;
  logic [DW-1:0]        pooled;

  assign lastCol = (col_q == LAST_IDX);
  assign lastWin = lastCol && (row_q == LAST_IDX);

  // Window sequencer: addresses step incrementally, jumping over the odd row at each row end.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    addr3_d    = addr3_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          addr0_d = '0;
          addr1_d = OFS_RIGHT;
          addr2_d = OFS_DOWN;
          addr3_d = OFS_DIAG;
        end
      end
      S_RUN: begin
        if (lastWin) begin
          state_d    = S_DRAIN;
          drainCnt_d = 1'b0;
        end else if (lastCol) begin
          col_d   = '0;
          row_d   = row_q + CW'(1);
          addr0_d = addr0_q + ROW_STEP;
          addr1_d = addr1_q + ROW_STEP;
          addr2_d = addr2_q + ROW_STEP;
          addr3_d = addr3_q + ROW_STEP;
        end else begin
          col_d   = col_q + CW'(1);
          addr0_d = addr0_q + COL_STEP;
          addr1_d = addr1_q + COL_STEP;
          addr2_d = addr2_q + COL_STEP;
          addr3_d = addr3_q + COL_STEP;
        end
      end
      S_DRAIN: begin
        if (drainCnt_q) begin
          state_d = S_DONE;
        end else begin
          drainCnt_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
        addr0_d = '0;
        addr1_d = '0;
        addr2_d = '0;
        addr3_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pix0 = $signed(rd_data0);
  assign pix1 = $signed(rd_data1);
  assign pix2 = $signed(rd_data2);
  assign pix3 = $signed(rd_data3);

  assign maxTop = (pix0 >= pix1) ? pix0 : pix1;
  assign maxBot = (pix2 >= pix3) ? pix2 : pix3;
  assign maxAll = (maxTop >= maxBot) ? maxTop : maxBot;

`ifdef MAXPOOL2X2_RELU_EN
  assign pooled = maxAll[DW-1] ? '0 : maxAll;
`else
  assign pooled = maxAll;
`endif

  // RAM data is valid the cycle after an address is issued; the write register follows it.
  always_comb begin
    dataVld_d = (state_q == S_RUN);
    wrEn_d    = dataVld_q;
    wrAddr_d  = dataVld_q ? wrIdx_q : '0;
    wrData_d  = dataVld_q ? pooled : '0;
    wrIdx_d   = wrIdx_q;
    if (state_q == S_IDLE) begin
      wrIdx_d = '0;
    end else if (dataVld_q) begin
      wrIdx_d = wrIdx_q + AW_OUT'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      addr3_q    <= '0;
      drainCnt_q <= 1'b0;
      dataVld_q  <= 1'b0;
      wrIdx_q    <= '0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      addr3_q    <= addr3_d;
      drainCnt_q <= drainCnt_d;
      dataVld_q  <= dataVld_d;
      wrIdx_q    <= wrIdx_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign rd_addr0 = addr0_q;
  assign rd_addr1 = addr1_q;
  assign rd_addr2 = addr2_q;
  assign rd_addr3 = addr3_q;
  assign wr_en    = wrEn_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;

endmodule

// File: doc/maxpool2x2_engine.md
Name: maxpool2x2_engine

Overview:
- Self-sequencing 2x2 stride-2 max-pool stage that sits directly downstream of the conv1/conv2 output memories.
- Generates four parallel read addresses per pooling window into a synchronous-read feature-map RAM.
- Computes the signed maximum of the four returned pixels and writes one pooled pixel per cycle into the pool output RAM.
- One instance per channel pass; IMG_W=24 for pool 1 (24x24 -> 12x12), IMG_W=8 for pool 2 (8x8 -> 4x4).

Parameters:
- IMG_W, 24, input feature-map width/height in pixels; must be even and >= 4.
- DW, 16, pixel width; two's-complement signed.
- Derived, not overridable: AW_IN = clog2(IMG_W*IMG_W); AW_OUT = clog2((IMG_W/2)^2); N = (IMG_W/2)^2 windows.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin one full-image pass; sampled only in IDLE.
- busy  out  1  high from the first RUN cycle until the last write cycle, inclusive.
- done  out  1  one-cycle pulse in the cycle after the last write.
- rd_addr0..rd_addr3  out  AW_IN each  window top-left, top-right, bottom-left, bottom-right addresses; registered.
- rd_data0..rd_data3  in  DW each  RAM read data; valid one cycle after the matching address.
- wr_en  out  1  pooled-pixel write strobe.
- wr_addr  out  AW_OUT  pooled-pixel address.
- wr_data  out  DW  pooled pixel.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; window row/column counters 0; pipeline valid bits 0. Takes effect immediately, including mid-pass. No partial write occurs after reset asserts.
- FSM states and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DRAIN after window N-1 addresses are issued.
  - DRAIN -> DONE when the last write has been issued (2 cycles).
  - DONE -> IDLE unconditionally after 1 cycle.
- start is ignored in RUN, DRAIN and DONE; no queuing.
- Window k = r*(IMG_W/2) + c, with r, c in 0..IMG_W/2-1, issued in raster order:
  - rd_addr0 = 2r*IMG_W + 2c
  - rd_addr1 = rd_addr0 + 1
  - rd_addr2 = rd_addr0 + IMG_W
  - rd_addr3 = rd_addr0 + IMG_W + 1
- Address stepping is incremental, with no multiplier:
  - Within a row: +2 per window.
  - At c = IMG_W/2-1: + (IMG_W + 2) to skip the odd row.
- Timing, with the start-sampling edge as cycle 0:
  - Window k addresses are on the ports during cycle k+1.
  - rd_data for window k arrives in cycle k+2.
  - wr_en=1, wr_addr=k and wr_data=max are registered and presented in cycle k+3.
  - Fixed latency: 2 cycles from address to write.
  - done pulses in cycle N+3; busy is high during cycles 1..N+2.
- Max is a signed compare as a two-level tree: max(max(d0,d1), max(d2,d3)). Ties may select any equal operand; the value is identical.
- wr_en is high for exactly N cycles per pass, contiguous, with no bubbles.
- wr_addr increments 0..N-1 and never wraps within a pass.
- rd_addr ports hold their last window value during DRAIN/DONE and return to 0 on entering IDLE.
- A new start in the IDLE cycle right after DONE is accepted; back-to-back passes are separated by exactly 1 IDLE cycle.

Optional Feature:
- Macro: MAXPOOL2X2_RELU_EN.
- Defined: the pooled result is clamped to 0 when negative (fused ReLU), applied after the max in the same register stage. Latency is unchanged.
- Undefined: the raw signed max is written. Negative values pass through.

Test Plan:
- Reset: hold reset=0 with start toggling -> busy, done, wr_en, wr_addr, wr_data and all rd_addr stay 0. Release -> remains IDLE until start.
- Ramp image, IMG_W=24, mem[i]=i, pulse start at cycle 0:
  - 144 contiguous writes, first at cycle 3.
  - wr_addr 0 -> data 25; wr_addr 1 -> data 27; wr_addr 12 -> data 73; wr_addr 143 -> data 575.
  - Last window rd_addr0..3 = 550, 551, 574, 575.
  - done=1 only at cycle 147.
- Signed window: pixels -5, -3, -7, -1 -> wr_data = -1 (0xFFFF) without MAXPOOL2X2_RELU_EN; 0x0000 with it. Window 7, 3, 9, -2 -> 9 in both builds.
- Start while busy: extra start pulses at cycles 10 and 146 -> no effect; exactly one done. A start at cycle 148 reruns with output identical to the first pass.
- Reset mid-pass: assert reset=0 after the 50th write -> all outputs 0 in the same cycle, no further writes. A fresh start restarts at window 0 with rd_addr0=0.
- IMG_W=8, ramp data: 16 writes with wr_addr 15 -> data 63; last rd_addr3 = 63; done at cycle 19; AW_IN=6, AW_OUT=4.
